// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcode map, state
// encoding, ALU operation codes, instruction field positions and the
// Moore output table used by the FSM.
package multicycle_controller_pkg;

    // Opcodes as delivered by the instruction decoder from inst[31:29]
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Instruction field positions shared with the decoder
    localparam int INST_OPCODE_HI = 31;
    localparam int INST_OPCODE_LO = 29;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_e;

    // Registered control word; one field per controller output
    typedef struct packed {
        logic       pc_en;
        logic       pc_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ab_load;
        logic [1:0] alu_op;
        logic       rf_we;
        logic       rf_wsel;
        logic       busy;
        logic       halted;
        logic       error;
    } ctrl_t;

    function automatic logic [2:0] opcode_of(input logic [31:0] inst);
        return inst[INST_OPCODE_HI:INST_OPCODE_LO];
    endfunction

    // Memory ops compute their address with ADD; NOP/JMP/HALT do not care
    function automatic logic [1:0] alu_for(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // Moore outputs for a state given the opcode latched for it
    function automatic ctrl_t ctrl_for(input state_e s, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.busy    = 1'b1;
            end
            S_DECODE: begin
                c.ab_load = 1'b1;
                c.busy    = 1'b1;
            end
            S_EXEC: begin
                c.alu_op = alu_for(op);
                c.busy   = 1'b1;
                if (op == OP_JMP) begin
                    c.pc_en  = 1'b1;
                    c.pc_sel = 1'b1;
                end
            end
            S_MEM: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.mem_we       = (op == OP_SW);
                c.busy         = 1'b1;
            end
            S_WB: begin
                c.rf_we   = 1'b1;
                c.rf_wsel = (op == OP_LW);
                c.alu_op  = alu_for(op);
                c.busy    = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            S_ERROR: c.error  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Memory wait counter: counts request cycles without mem_ready.
module multicycle_controller_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    // Clear on reset or state change, otherwise count stalled request cycles
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory wait timeout, sticky HALT and ERROR states.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       ir_load,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ab_load,
    output logic [1:0] alu_op,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    state_e     r_state;
    state_e     w_state_next;
    logic [2:0] r_op;
    logic [2:0] w_op_next;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;
    logic [7:0] w_wait_count;
    logic       w_timeout;
    logic       w_fetch_done;

    // Timeout fires on the MAX_WAIT-th stalled cycle; mem_ready takes priority
    assign w_timeout = r_ctrl.mem_req && !mem_ready
                       && (w_wait_count == 8'(MAX_WAIT - 1));

    multicycle_controller_wait_timer u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_state_next != r_state),
        .i_inc   (r_ctrl.mem_req && !mem_ready),
        .o_count (w_wait_count)
    );

    // Opcode is captured only while leaving DECODE
    always_comb begin
        w_op_next = (r_state == S_DECODE) ? opcode : r_op;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_DECODE: w_state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (r_op)
                    OP_NOP, OP_JMP: w_state_next = S_FETCH;
                    OP_LW, OP_SW:   w_state_next = S_MEM;
                    default:        w_state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      w_state_next = (r_op == OP_LW) ? S_WB : S_FETCH;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_WB:     w_state_next = S_FETCH;
            default:  w_state_next = r_state;
        endcase
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        w_ctrl_next = ctrl_for(w_state_next, w_op_next);
    end

    // State, latched opcode and registered Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    // The fetch completes in the same cycle memory answers, so IR/PC load
    // must follow mem_ready directly rather than wait a cycle
    assign w_fetch_done = (r_state == S_FETCH) && mem_ready;

    assign ir_load      = w_fetch_done;
    assign pc_en        = r_ctrl.pc_en | w_fetch_done;
    assign pc_sel       = r_ctrl.pc_sel;
    assign mem_req      = r_ctrl.mem_req;
    assign mem_we       = r_ctrl.mem_we;
    assign mem_addr_sel = r_ctrl.mem_addr_sel;
    assign ab_load      = r_ctrl.ab_load;
    assign alu_op       = r_ctrl.alu_op;
    assign rf_we        = r_ctrl.rf_we;
    assign rf_wsel      = r_ctrl.rf_wsel;
    assign busy         = r_ctrl.busy;
    assign halted       = r_ctrl.halted;
    assign error        = r_ctrl.error;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MAX_WAIT=4): every cycle pushes
// the expected output word to a scoreboard and compares it once the DUT
// has settled.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       pc_en, pc_sel, ir_load, mem_req, mem_we, mem_addr_sel;
    logic       ab_load, rf_we, rf_wsel, busy, halted, error;
    logic [1:0] alu_op;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic [13:0] exp;
        string       tag;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    // Output word: pc_en pc_sel ir_load mem_req mem_we mem_addr_sel ab_load
    //              alu_op[1:0] rf_we rf_wsel busy halted error
    localparam logic [13:0] E_IDLE       = 14'b00_0000_0000_0000;
    localparam logic [13:0] E_FETCH_WAIT = 14'b00_0100_0000_0100;
    localparam logic [13:0] E_FETCH_DONE = 14'b10_1100_0000_0100;
    localparam logic [13:0] E_DECODE     = 14'b00_0000_1000_0100;
    localparam logic [13:0] E_EXEC_ADD   = 14'b00_0000_0000_0100;
    localparam logic [13:0] E_EXEC_SUB   = 14'b00_0000_0010_0100;
    localparam logic [13:0] E_EXEC_AND   = 14'b00_0000_0100_0100;
    localparam logic [13:0] E_EXEC_JMP   = 14'b11_0000_0000_0100;
    localparam logic [13:0] E_MEM_LW     = 14'b00_0101_0000_0100;
    localparam logic [13:0] E_MEM_SW     = 14'b00_0111_0000_0100;
    localparam logic [13:0] E_WB_ADD     = 14'b00_0000_0001_0100;
    localparam logic [13:0] E_WB_SUB     = 14'b00_0000_0011_0100;
    localparam logic [13:0] E_WB_AND     = 14'b00_0000_0101_0100;
    localparam logic [13:0] E_WB_LW      = 14'b00_0000_0001_1100;
    localparam logic [13:0] E_HALT       = 14'b00_0000_0000_0010;
    localparam logic [13:0] E_ERROR      = 14'b00_0000_0000_0001;

    multicycle_controller #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .ir_load      (ir_load),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ab_load      (ab_load),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .busy         (busy),
        .halted       (halted),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of stimulus, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_output();
        sb_entry_t   e;
        logic [13:0] obs;
        obs = {pc_en, pc_sel, ir_load, mem_req, mem_we, mem_addr_sel, ab_load,
               alu_op, rf_we, rf_wsel, busy, halted, error};
        e = sb_q.pop_front();
        vectors_applied++;
        $display("vec %0d %s: outputs %b expected %b", vectors_applied, e.tag, obs, e.exp);
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare, advance
    task automatic step(input logic r, input logic s, input logic [2:0] op,
                        input logic rdy, input logic [13:0] exp, input string tag);
        sb_entry_t e;
        rst       = r;
        start     = s;
        opcode    = op;
        mem_ready = rdy;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        #2;
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 3'b000; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 3'b000, 0, E_IDLE, "reset");
        step(0, 0, 3'b000, 1, E_IDLE, "idle_hold");

        // ADD, zero-wait: FETCH DECODE EXEC WB
        step(0, 1, 3'b000, 0, E_IDLE,       "add_start");
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "add_fetch");
        step(0, 0, 3'b001, 0, E_DECODE,     "add_decode");
        step(0, 1, 3'b111, 0, E_EXEC_ADD,   "add_exec");
        step(0, 0, 3'b000, 0, E_WB_ADD,     "add_wb");

        // SUB
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "sub_fetch");
        step(0, 0, 3'b100, 0, E_DECODE,     "sub_decode");
        step(0, 0, 3'b000, 0, E_EXEC_SUB,   "sub_exec");
        step(0, 0, 3'b000, 0, E_WB_SUB,     "sub_wb");

        // AND
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "and_fetch");
        step(0, 0, 3'b101, 0, E_DECODE,     "and_decode");
        step(0, 0, 3'b000, 0, E_EXEC_AND,   "and_exec");
        step(0, 0, 3'b000, 0, E_WB_AND,     "and_wb");

        // LW, memory answers on the 4th request cycle (the timeout boundary)
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "lw_fetch");
        step(0, 0, opcode_of(32'h41080007), 0, E_DECODE, "lw_decode");
        step(0, 0, 3'b000, 0, E_EXEC_ADD,   "lw_exec");
        step(0, 0, 3'b000, 0, E_MEM_LW,     "lw_mem_w1");
        step(0, 0, 3'b000, 0, E_MEM_LW,     "lw_mem_w2");
        step(0, 0, 3'b000, 0, E_MEM_LW,     "lw_mem_w3");
        step(0, 0, 3'b000, 1, E_MEM_LW,     "lw_mem_rdy");
        step(0, 0, 3'b000, 1, E_WB_LW,      "lw_wb");

        // SW: MEM with mem_we, then straight back to FETCH
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "sw_fetch");
        step(0, 0, opcode_of(32'h61180006), 0, E_DECODE, "sw_decode");
        step(0, 0, 3'b000, 0, E_EXEC_ADD,   "sw_exec");
        step(0, 0, 3'b000, 1, E_MEM_SW,     "sw_mem");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "sw_next_fetch");

        // JMP
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "jmp_fetch");
        step(0, 0, 3'b110, 0, E_DECODE,     "jmp_decode");
        step(0, 0, 3'b000, 0, E_EXEC_JMP,   "jmp_exec");

        // NOP whose fetch completes on the 4th request cycle
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "nop_fetch_w1");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "nop_fetch_w2");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "nop_fetch_w3");
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "nop_fetch_rdy");
        step(0, 0, 3'b000, 0, E_DECODE,     "nop_decode");
        step(0, 0, 3'b000, 0, E_EXEC_ADD,   "nop_exec");

        // Reset while SW is in MEM
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "rsw_fetch");
        step(0, 0, 3'b011, 0, E_DECODE,     "rsw_decode");
        step(0, 0, 3'b000, 0, E_EXEC_ADD,   "rsw_exec");
        step(1, 0, 3'b000, 0, E_MEM_SW,     "rsw_mem_rst");
        step(0, 0, 3'b000, 0, E_IDLE,       "rsw_after_rst");

        // Timeout: four stalled FETCH cycles then sticky ERROR
        step(0, 1, 3'b000, 0, E_IDLE,       "to_start");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "to_w1");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "to_w2");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "to_w3");
        step(0, 0, 3'b000, 0, E_FETCH_WAIT, "to_w4");
        step(0, 0, 3'b000, 0, E_ERROR,      "to_error");
        step(0, 1, 3'b000, 1, E_ERROR,      "to_sticky_start");
        step(1, 0, 3'b000, 0, E_ERROR,      "to_rst_edge");
        step(0, 0, 3'b000, 0, E_IDLE,       "to_after_rst");

        // HALT is sticky, start ignored, rst returns to IDLE
        step(0, 1, 3'b000, 0, E_IDLE,       "halt_start");
        step(0, 0, 3'b000, 1, E_FETCH_DONE, "halt_fetch");
        step(0, 0, opcode_of(32'hE208E000), 0, E_DECODE, "halt_decode");
        step(0, 1, 3'b000, 1, E_HALT,       "halt_state");
        step(0, 1, 3'b000, 0, E_HALT,       "halt_sticky");
        step(1, 0, 3'b000, 0, E_HALT,       "halt_rst_edge");
        step(0, 0, 3'b000, 0, E_IDLE,       "halt_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MAX_WAIT, 15, maximum cycles the block waits for mem_ready per access before it enters ERROR; legal range 1..255.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  begin execution from IDLE.
REQ-005 Port: opcode  in  3  decoded opcode from the instruction decoder (inst[31:29]); sampled only in DECODE.
REQ-006 Port: mem_ready  in  1  memory completes the current access this cycle.
REQ-007 Port: pc_en  out  1  PC register load enable.
REQ-008 Port: pc_sel  out  1  PC source: 0 = PC+1, 1 = instruction addr field (jump).
REQ-009 Port: ir_load  out  1  instruction register load enable.
REQ-010 Port: mem_req  out  1  memory access request, held until mem_ready.
REQ-011 Port: mem_we  out  1  memory write (valid with mem_req).
REQ-012 Port: mem_addr_sel  out  1  memory address source: 0 = PC, 1 = addr field.
REQ-013 Port: ab_load  out  1  load operand registers A/B from the register file.
REQ-014 Port: alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-015 Port: rf_we  out  1  register file write enable (destination reg_addr_0).
REQ-016 Port: rf_wsel  out  1  write-back source: 0 = ALU result, 1 = memory data.
REQ-017 Port: busy  out  1  high in every state except IDLE, HALT and ERROR.
REQ-018 Port: halted  out  1  high in HALT.
REQ-019 Port: error  out  1  high in ERROR.

Function
REQ-020 Opcode map: 000 NOP, 001 ADD, 010 LW, 011 SW, 100 SUB, 101 AND, 110 JMP, 111 HALT.
REQ-021 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR; Moore outputs, all outputs 0 unless stated.
REQ-022 IDLE: go to FETCH when start=1, otherwise remain in IDLE.
REQ-023 FETCH: mem_req=1, mem_addr_sel=0; on mem_ready assert ir_load=1 and pc_en=1 (pc_sel=0) in that same cycle, then go to DECODE.
REQ-024 DECODE: ab_load=1; latch opcode; HALT goes to HALT, every other opcode goes to EXEC.
REQ-025 EXEC: alu_op per latched opcode (LW/SW use ADD); NOP returns to FETCH; JMP asserts pc_en=1, pc_sel=1 and returns to FETCH; ADD/SUB/AND/OR go to WB; LW/SW go to MEM.
REQ-026 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW; on mem_ready, LW goes to WB and SW goes to FETCH.
REQ-027 WB: rf_we=1; rf_wsel=1 for LW, 0 otherwise; alu_op held from EXEC; then go to FETCH.
REQ-028 Latency with zero-wait memory (mem_ready high in the first request cycle): NOP/JMP 3 cycles, ALU ops 4, SW 4, LW 5 from FETCH entry to the next FETCH entry.
REQ-029 Wait counter: 8-bit; cleared on entry to FETCH or MEM; increments each cycle mem_req=1 and mem_ready=0; when it reaches MAX_WAIT with mem_ready still 0, go to ERROR on that edge.
REQ-030 mem_ready and the timeout limit in the same cycle: mem_ready wins and the access completes.
REQ-031 mem_ready outside FETCH/MEM: ignored.
REQ-032 start outside IDLE: ignored.
REQ-033 HALT and ERROR: sticky; exited only by rst.

Reset
REQ-034 On rst=1 at a clock edge: state becomes IDLE, wait counter and latched opcode become 0, and all outputs become 0 in the following cycle.
REQ-035 Reset mid-access (FETCH/MEM) drops mem_req the next cycle, with no partial write-back or PC update.

Structure
REQ-036 Shared package holds: opcode constants, state enum, alu_op encodings, instruction field positions shared with the decoder.
REQ-037 No sub-module required; the wait counter may be a separate module wait_timer.

Verification
REQ-038 rst, start, opcode=001, mem_ready=1 -> FETCH,DECODE,EXEC,WB; rf_we=1 in cycle 4 with alu_op=00, rf_wsel=0.
REQ-039 opcode=010 (inst 0x41080007), mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles at mem_addr_sel=1; WB with rf_wsel=1.
REQ-040 opcode=011 (inst 0x61180006) -> MEM with mem_we=1, no rf_we, next state FETCH.
REQ-041 opcode=111 (inst 0xE208E000) -> HALT, halted=1, busy=0; start ignored; only rst returns to IDLE.
REQ-042 MAX_WAIT=4, mem_ready held 0 in FETCH -> error=1 after exactly 4 request cycles; mem_ready=1 on the 4th cycle -> no error.
REQ-043 rst asserted in MEM during SW -> next cycle state IDLE, mem_req=0, mem_we=0.
